// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot iterator: FSM encoding and fixed-point helpers.
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Escape radius squared, in units of 1.0.
  localparam int unsigned ESC_INT = 4;

  function automatic int unsigned frac_bits(input int unsigned w);
    return w - 32'd2;
  endfunction

  function automatic int unsigned one_val(input int unsigned w);
    return 32'd1 << frac_bits(w);
  endfunction

endpackage

// File: rtl/mandelbrot_step.sv
// One Mandelbrot step z' = z^2 + c in signed 2.(WIDTH-2), with escape and overflow flags.
module mandelbrot_step
  import mandelbrot_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_zr,
  input  logic [WIDTH-1:0] i_zi,
  input  logic [WIDTH-1:0] i_cr,
  input  logic [WIDTH-1:0] i_ci,
  output logic [WIDTH-1:0] o_zr,
  output logic [WIDTH-1:0] o_zi,
  output logic             o_big,
  output logic             o_ovf
);

  localparam int unsigned F   = frac_bits(WIDTH);
  localparam int unsigned WP  = 2 * WIDTH;
  localparam int unsigned WP1 = WP + 1;
  localparam int unsigned WX  = WP + 2;
  localparam logic signed [WP1-1:0] THRESH = WP1'(ESC_INT) << (2 * F);

  logic signed [WIDTH-1:0] w_zr, w_zi, w_cr, w_ci;
  logic signed [WP-1:0]    w_zr2, w_zi2, w_zrzi;
  logic signed [WP1-1:0]   w_mag;
  logic signed [WX-1:0]    w_re_x, w_im_x;

  assign w_zr = i_zr;
  assign w_zi = i_zi;
  assign w_cr = i_cr;
  assign w_ci = i_ci;

  assign w_zr2  = WP'(w_zr) * WP'(w_zr);
  assign w_zi2  = WP'(w_zi) * WP'(w_zi);
  assign w_zrzi = WP'(w_zr) * WP'(w_zi);

  // Magnitude of the current z, compared before the step is taken.
  assign w_mag = WP1'(w_zr2) + WP1'(w_zi2);
  assign o_big = (w_mag > THRESH);

  // Arithmetic shift truncates toward minus infinity; c has no fraction bits below F.
  assign w_re_x = ((WX'(w_zr2) - WX'(w_zi2)) >>> F) + WX'(w_cr);
  assign w_im_x = ((WX'(w_zrzi) <<< 1) >>> F) + WX'(w_ci);

  // Representable iff every bit above the result's sign bit matches it.
  assign o_ovf = ~((&w_re_x[WX-1:WIDTH-1]) | ~(|w_re_x[WX-1:WIDTH-1]))
               | ~((&w_im_x[WX-1:WIDTH-1]) | ~(|w_im_x[WX-1:WIDTH-1]));

  assign o_zr = w_re_x[WIDTH-1:0];
  assign o_zi = w_im_x[WIDTH-1:0];

endmodule

// File: rtl/mandelbrot_iter.sv
// Iterates one Mandelbrot point per job with a valid/ready handshake on both sides.
module mandelbrot_iter
  import mandelbrot_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_cr,
  input  logic [WIDTH-1:0]  in_ci,
  input  logic [ITER_W-1:0] in_max_iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_count,
  output logic              out_escaped
);

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_cr, r_ci, r_zr, r_zi;
  logic [WIDTH-1:0]    w_cr_nxt, w_ci_nxt, w_zr_nxt, w_zi_nxt;
  logic [ITER_W-1:0]   r_n, w_n_nxt, r_count, w_count_nxt, w_count_inc;
  logic                r_escaped, w_escaped_nxt;
  logic                r_in_ready, r_out_valid;
  logic [WIDTH-1:0]    w_step_zr, w_step_zi;
  logic                w_big, w_ovf;

  mandelbrot_step #(.WIDTH(WIDTH)) u_step (
    .i_zr  (r_zr),
    .i_zi  (r_zi),
    .i_cr  (r_cr),
    .i_ci  (r_ci),
    .o_zr  (w_step_zr),
    .o_zi  (w_step_zi),
    .o_big (w_big),
    .o_ovf (w_ovf)
  );

  assign w_count_inc = r_count + ITER_W'(1);

  // Next-state and datapath update; clear overrides every handshake.
  always_comb begin
    w_state_nxt   = r_state;
    w_cr_nxt      = r_cr;
    w_ci_nxt      = r_ci;
    w_n_nxt       = r_n;
    w_zr_nxt      = r_zr;
    w_zi_nxt      = r_zi;
    w_count_nxt   = r_count;
    w_escaped_nxt = r_escaped;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            w_cr_nxt      = in_cr;
            w_ci_nxt      = in_ci;
            w_n_nxt       = in_max_iter;
            w_zr_nxt      = '0;
            w_zi_nxt      = '0;
            w_count_nxt   = '0;
            w_escaped_nxt = 1'b0;
            w_state_nxt   = (in_max_iter == '0) ? ST_DONE : ST_ITER;
          end
        end
        ST_ITER: begin
          if (w_big || w_ovf) begin
            w_escaped_nxt = 1'b1;
            w_state_nxt   = ST_DONE;
          end else begin
            w_zr_nxt    = w_step_zr;
            w_zi_nxt    = w_step_zi;
            w_count_nxt = w_count_inc;
            if (w_count_inc == r_n) begin
              w_escaped_nxt = 1'b0;
              w_state_nxt   = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cr        <= '0;
      r_ci        <= '0;
      r_n         <= '0;
      r_zr        <= '0;
      r_zi        <= '0;
      r_count     <= '0;
      r_escaped   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cr        <= w_cr_nxt;
      r_ci        <= w_ci_nxt;
      r_n         <= w_n_nxt;
      r_zr        <= w_zr_nxt;
      r_zi        <= w_zi_nxt;
      r_count     <= w_count_nxt;
      r_escaped   <= w_escaped_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_count   = r_count;
  assign out_escaped = r_escaped;

endmodule
